// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width codes for loads and stores
//   - FSM state enum
//   - byte-enable width
//   - helpers that classify a funct3 code as legal or misaligned
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_WAIT = 3'd1,
    LOAD_DATA = 3'd2,
    STORE     = 3'd3,
    RESP      = 3'd4
  } state_t;

  // Stores only know B/H/W; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) ||
           ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational load-data extraction.
// Ports:
//   i_word    in  32  RAM read word
//   i_addr_lo in  2   byte offset within the word
//   i_funct3  in  3   load width code
//   o_data    out 32  byte/half/word, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'(i_word >> {i_addr_lo, 3'b000});
    w_half = 16'(i_word >> {i_addr_lo[1], 4'b0000});
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and a byte-enabled word RAM.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses raise
// rsp_err instead of having their low address bits forced to 0).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we, req_funct3        store flag and RV32I width code
//   req_addr, req_wdata       byte address and right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response pulse
//   mem_r_addr, mem_r_val     RAM read port (1-cycle registered read)
//   mem_w_enable, mem_w_addr, mem_w_val, mem_byte_en  RAM write port
// Handshake: a request transfers on a rising edge with req_valid && req_ready;
// req_ready is high only in IDLE, requests at other times are dropped, and
// rsp_valid is a single-cycle pulse that cannot be stalled.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-3:0] mem_r_addr,
  input  logic [XLEN-1:0] mem_r_val,
  output logic            mem_w_enable,
  output logic [XLEN-3:0] mem_w_addr,
  output logic [XLEN-1:0] mem_w_val,
  output logic [BE_W-1:0] mem_byte_en
);

  state_t          r_state;
  logic [1:0]      r_addr_lo;
  logic [2:0]      r_funct3;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_err;
  logic [XLEN-3:0] r_mem_r_addr;
  logic            r_mem_w_enable;
  logic [XLEN-3:0] r_mem_w_addr;
  logic [XLEN-1:0] r_mem_w_val;
  logic [BE_W-1:0] r_mem_byte_en;

  logic            w_err;
  logic [XLEN-1:0] w_addr_eff;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wval;
  logic [XLEN-1:0] w_load_data;

  // Request decode: error detection and the effective (possibly masked) address.
  always_comb begin
    w_addr_eff = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    w_err = !f3_legal(req_we, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
`else
    w_err = !f3_legal(req_we, req_funct3);
    // Misaligned halves/words silently drop the offending low bits.
    if (req_funct3[1:0] == 2'b01) w_addr_eff[0] = 1'b0;
    else if (req_funct3[1:0] == 2'b10) w_addr_eff[1:0] = 2'b00;
`endif
  end

  // Store lane steering; only meaningful for legal store codes.
  always_comb begin
    w_be   = 4'b1111;
    w_wval = req_wdata;
    case (req_funct3)
      F3_B: begin
        w_be   = 4'b0001 << w_addr_eff[1:0];
        w_wval = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        w_be   = 4'b0011 << {w_addr_eff[1], 1'b0};
        w_wval = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_align u_align (
    .i_word    (mem_r_val),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  // Single FSM; all outputs are registered. Memory outputs are loaded on the
  // transition into the state that uses them and cleared on the way out, so
  // mem_byte_en is non-zero only while in STORE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_addr_lo      <= '0;
      r_funct3       <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_err      <= 1'b0;
      r_mem_r_addr   <= '0;
      r_mem_w_enable <= 1'b0;
      r_mem_w_addr   <= '0;
      r_mem_w_val    <= '0;
      r_mem_byte_en  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            // Only the byte offset and width are needed after accept; the
            // word address and store data go straight into the mem_* registers.
            r_addr_lo   <= w_addr_eff[1:0];
            r_funct3    <= req_funct3;
            r_rsp_rdata <= '0;
            if (w_err) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (req_we) begin
              r_state        <= STORE;
              r_mem_w_enable <= 1'b1;
              r_mem_w_addr   <= w_addr_eff[XLEN-1:2];
              r_mem_w_val    <= w_wval;
              r_mem_byte_en  <= w_be;
            end else begin
              r_state      <= LOAD_WAIT;
              r_mem_r_addr <= w_addr_eff[XLEN-1:2];
            end
          end
        end
        LOAD_WAIT: begin
          // The RAM samples mem_r_addr on this edge; data arrives next cycle.
          r_state      <= LOAD_DATA;
          r_mem_r_addr <= '0;
        end
        LOAD_DATA: begin
          r_state     <= RESP;
          r_rsp_rdata <= w_load_data;
          r_rsp_valid <= 1'b1;
        end
        STORE: begin
          r_state        <= RESP;
          r_rsp_valid    <= 1'b1;
          r_mem_w_enable <= 1'b0;
          r_mem_w_addr   <= '0;
          r_mem_w_val    <= '0;
          r_mem_byte_en  <= '0;
        end
        RESP: begin
          r_state     <= IDLE;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign mem_r_addr   = r_mem_r_addr;
  assign mem_w_enable = r_mem_w_enable;
  assign mem_w_addr   = r_mem_w_addr;
  assign mem_w_val    = r_mem_w_val;
  assign mem_byte_en  = r_mem_byte_en;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the data-port pair of the dual-read, byte-enabled word RAM. Accepts one RV32I load or store per request and computes the word address, byte enables and lane-replicated write data. For loads, extracts and sign/zero-extends the addressed byte, half or word from the RAM's registered 1-cycle read data. Detects illegal width codes and, optionally, misaligned accesses.

## Interface
Parameters:
- XLEN, 32, data and byte-address width; fixed at 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  LSU idle; a request is accepted on `req_valid && req_ready`.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse; no back-pressure.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  access rejected; memory untouched.
- mem_r_addr  out  30  word address to RAM read port 2.
- mem_r_val  in  32  RAM read port 2 data, valid one cycle after `mem_r_addr` is sampled.
- mem_w_enable  out  1  write strobe.
- mem_w_addr  out  30  write word address.
- mem_w_val  out  32  lane-replicated write data.
- mem_byte_en  out  4  per-byte write enables.

## Operation
- States: IDLE, LOAD_WAIT, LOAD_DATA, STORE, RESP. `req_ready` = (state == IDLE).
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal: IDLE→RESP with `rsp_err`=1 and no memory access.
- Accept (IDLE):
  - Register addr, funct3 and wdata.
  - A legal load goes to LOAD_WAIT and a legal store goes to STORE.
- Load path:
  - LOAD_WAIT: `mem_r_addr` = addr[31:2] (registered at accept), sampled by the RAM at the end of this cycle.
  - LOAD_DATA: extract from `mem_r_val`:
    - byte = word >> 8·a[1:0];
    - half = word >> 16·a[1];
    - B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
    - Register the result into `rsp_rdata`, then go to RESP.
- Store path (STORE state, outputs registered):
  - `mem_w_enable`=1, `mem_w_addr`=addr[31:2].
  - SB: `mem_byte_en` = 0001 << a[1:0]; `mem_w_val` = {4{wdata[7:0]}}.
  - SH: `mem_byte_en` = 0011 << 2·a[1]; `mem_w_val` = {2{wdata[15:0]}}.
  - SW: `mem_byte_en` = 1111; `mem_w_val` = wdata.
  - Next state: RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- The RAM writes on `mem_byte_en` alone. `mem_byte_en` MUST be 0000 in every state except STORE, and `mem_w_enable` must equal (state == STORE).
- Misalignment: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]≠0 (handling in Configuration).

## Timing
- Accept edge = cycle 0. `rsp_valid` is high in:
  - cycle 3 for a load;
  - cycle 2 for a store;
  - cycle 1 for an error.
- Next accept is possible on the cycle after `rsp_valid`, so throughput is one load per 4 cycles and one store per 3 cycles.
- Reset values:
  - state IDLE, so `req_ready`=1;
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0;
  - all `mem_*` outputs 0.
- Reset mid-operation:
  - Abort to IDLE with no response.
  - A store already in STORE at the reset edge completes, because the RAM has no reset and samples the same edge.
  - `mem_byte_en` is 0 from the following cycle.
- `req_valid` outside IDLE is ignored and not queued.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access is rejected exactly like an illegal funct3: `rsp_err`=1 in cycle 1 and no memory access.
- Undefined:
  - The offending low bits are forced to 0: a[0] for half accesses, a[1:0] for word accesses.
  - The access proceeds normally; `rsp_err` is raised only for an illegal funct3.

## Structure
- Shared package `lsu_pkg` holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum;
  - the byte-enable width constant.
- Combinational sub-module `lsu_align`: inputs word, a[1:0] and funct3; output is the extended load data. It is reused by the load path and by the verification scoreboard.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF → cycle 1: `mem_w_addr`=4, `mem_byte_en`=1111, `mem_w_val`=0xDEADBEEF; cycle 2: `rsp_valid`=1, `rsp_err`=0.
- SB addr 0x13, wdata 0x000000A5 → `mem_byte_en`=1000, `mem_w_val`=0xA5A5A5A5; SH addr 0x12, wdata 0x1234 → `mem_byte_en`=1100, `mem_w_val`=0x12341234.
- Word 4 = 0x80FF7F01, with `rsp_rdata` checked in cycle 3:
  - LB 0x13 → 0xFFFFFF80;
  - LBU 0x13 → 0x00000080;
  - LH 0x12 → 0xFFFF80FF;
  - LHU 0x10 → 0x00007F01;
  - LW 0x10 → 0x80FF7F01.
- LW addr 0x16:
  - with the macro → `rsp_err`=1 in cycle 1, `mem_byte_en`=0000 throughout, `rsp_rdata`=0;
  - without the macro → returns word 5.
- funct3=011 (load) or 100 (store) → `rsp_err`=1 in cycle 1, no write strobe.
- `rst` asserted during LOAD_WAIT → no `rsp_valid`, `req_ready`=1 the next cycle, all `mem_*`=0; a following SW completes normally.
